// File: rtl/merge_stage.sv
// Two-input pipeline merge stage: burst-limited round-robin arbitration into one
// registered output stage, with saturating per-source acceptance counters.
module merge_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned BURST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         v_i1,
    input  logic [W-1:0] data_i1,
    output logic         stall_o1,
    input  logic         v_i2,
    input  logic [W-1:0] data_i2,
    output logic         stall_o2,
    output logic         v_o,
    output logic [W-1:0] data_o,
    output logic         src_o,
    input  logic         stall_i,
    output logic [15:0]  gcnt1_o,
    output logic [15:0]  gcnt2_o
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BCNT_W  = 4;
    localparam int unsigned CMP_W   = BCNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              v_r;
    logic [W-1:0]      data_r;
    logic              src_r;
    logic              pri;
    logic [BCNT_W-1:0] bcnt;
    logic [CNT_W-1:0]  gcnt1;
    logic [CNT_W-1:0]  gcnt2;

    logic en;
    logic gnt1;
    logic gnt2;
    logic contested;
    logic acc1;
    logic acc2;
    logic burst_end;

    // Arbitration: a bubble in the output register is always refilled.
    always_comb begin
        en        = ~(v_r & stall_i);
        contested = v_i1 & v_i2;
        gnt1      = v_i1 & (~v_i2 | ~pri);
        gnt2      = v_i2 & (~v_i1 | pri);
        acc1      = en & gnt1;
        acc2      = en & gnt2;
        burst_end = (CMP_W'(bcnt) + CMP_W'(1)) == CMP_W'(BURST);
    end

    // Output register and round-robin state; stalled cycles hold everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r    <= 1'b0;
            data_r <= '0;
            src_r  <= 1'b0;
            pri    <= 1'b0;
            bcnt   <= '0;
        end else if (en) begin
            if (gnt1 | gnt2) begin
                v_r    <= 1'b1;
                data_r <= gnt1 ? data_i1 : data_i2;
                src_r  <= gnt2;
            end else begin
                v_r <= 1'b0;
            end
            if (contested) begin
                if (burst_end) begin
                    pri  <= ~pri;
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + BCNT_W'(1);
                end
            end
        end
    end

    // Saturating debug counters of accepted words.
    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt1 <= '0;
            gcnt2 <= '0;
        end else begin
            if (acc1 && gcnt1 != CNT_MAX) gcnt1 <= gcnt1 + CNT_W'(1);
            if (acc2 && gcnt2 != CNT_MAX) gcnt2 <= gcnt2 + CNT_W'(1);
        end
    end

    assign stall_o1 = v_i1 & ~acc1;
    assign stall_o2 = v_i2 & ~acc2;
    assign v_o      = v_r;
    assign data_o   = data_r;
    assign src_o    = src_r;
    assign gcnt1_o  = gcnt1;
    assign gcnt2_o  = gcnt2;

endmodule

// File: tb/tb_merge_stage.sv
// Bench for merge_stage: BURST=1 and BURST=3 instances share stimulus and are
// compared each cycle against a reference model of the arbitration rules.
module tb_merge_stage;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         v_i1, v_i2, stall_i;
    logic [W-1:0] data_i1, data_i2;

    logic         so1 [2];
    logic         so2 [2];
    logic         ov  [2];
    logic [W-1:0] od  [2];
    logic         os  [2];
    logic [15:0]  oc1 [2];
    logic [15:0]  oc2 [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state per instance.
    int unsigned  burst [2] = '{1, 3};
    logic         mv [2];
    logic [W-1:0] md [2];
    logic         ms [2];
    int unsigned  mc1 [2];
    int unsigned  mc2 [2];
    int unsigned  ncont [2];

    always #5 clk = ~clk;

    merge_stage #(.W(W), .BURST(1)) dut1 (
        .clk(clk), .reset(reset),
        .v_i1(v_i1), .data_i1(data_i1), .stall_o1(so1[0]),
        .v_i2(v_i2), .data_i2(data_i2), .stall_o2(so2[0]),
        .v_o(ov[0]), .data_o(od[0]), .src_o(os[0]), .stall_i(stall_i),
        .gcnt1_o(oc1[0]), .gcnt2_o(oc2[0])
    );

    merge_stage #(.W(W), .BURST(3)) dut3 (
        .clk(clk), .reset(reset),
        .v_i1(v_i1), .data_i1(data_i1), .stall_o1(so1[1]),
        .v_i2(v_i2), .data_i2(data_i2), .stall_o2(so2[1]),
        .v_o(ov[1]), .data_o(od[1]), .src_o(os[1]), .stall_i(stall_i),
        .gcnt1_o(oc1[1]), .gcnt2_o(oc2[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Favoured source follows from how many contested grants have happened:
    // blocks of BURST contested grants alternate between source 1 and 2.
    function automatic int grant(input int k);
        int fav;
        fav = int'((ncont[k] / burst[k]) % 2);
        if (v_i1 && v_i2) return fav + 1;
        if (v_i1) return 1;
        if (v_i2) return 2;
        return 0;
    endfunction

    task automatic cycle(input logic r, input logic v1, input logic v2, input logic st,
                         input logic [W-1:0] d1, input logic [W-1:0] d2);
        int  g [2];
        bit  en [2];
        @(negedge clk);
        reset = r; v_i1 = v1; v_i2 = v2; stall_i = st; data_i1 = d1; data_i2 = d2;
        #1;
        for (int k = 0; k < 2; k++) begin
            en[k] = !(mv[k] && st);
            g[k]  = en[k] ? grant(k) : 0;
            if (!r) begin
                check($sformatf("stall1[%0d]", k), 32'(so1[k]), 32'(v1 && g[k] != 1));
                check($sformatf("stall2[%0d]", k), 32'(so2[k]), 32'(v2 && g[k] != 2));
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mv[k] = 0; md[k] = '0; ms[k] = 0; mc1[k] = 0; mc2[k] = 0; ncont[k] = 0;
            end else if (en[k]) begin
                if (g[k] != 0) begin
                    mv[k] = 1;
                    md[k] = (g[k] == 1) ? d1 : d2;
                    ms[k] = (g[k] == 2);
                    if (v1 && v2) ncont[k]++;
                    if (g[k] == 1) mc1[k] = (mc1[k] < 65535) ? mc1[k] + 1 : 65535;
                    else           mc2[k] = (mc2[k] < 65535) ? mc2[k] + 1 : 65535;
                end else begin
                    mv[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("v_o[%0d]", k), 32'(ov[k]), 32'(mv[k]));
            if (mv[k] || r) begin
                check($sformatf("data_o[%0d]", k), od[k], md[k]);
                check($sformatf("src_o[%0d]", k), 32'(os[k]), 32'(ms[k]));
            end
            check($sformatf("gcnt1[%0d]", k), 32'(oc1[k]), mc1[k]);
            check($sformatf("gcnt2[%0d]", k), 32'(oc2[k]), mc2[k]);
        end
    endtask

    initial begin
        reset = 1; v_i1 = 0; v_i2 = 0; stall_i = 0; data_i1 = '0; data_i2 = '0;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; md[k] = '0; ms[k] = 0; mc1[k] = 0; mc2[k] = 0; ncont[k] = 0;
        end

        // Reset with both sources valid, then first cycle out of reset.
        cycle(1, 1, 1, 0, 32'h11, 32'h22);
        cycle(1, 1, 1, 0, 32'h11, 32'h22);
        check("rst_v_o", 32'(ov[0]), 32'h0);
        cycle(0, 1, 1, 0, 32'h11, 32'h22);

        // Single source 2 stream.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 32'h0, 32'hA0 + 32'(i));
        check("single_data_last", od[0], 32'hA4);
        check("single_gcnt2", 32'(oc2[0]), 32'd5);
        cycle(0, 0, 0, 0, 32'h0, 32'h0);

        // Contested streams from reset.
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, $urandom, $urandom);
        check("cont_gcnt1_b1", 32'(oc1[0]), 32'd3);
        check("cont_gcnt2_b1", 32'(oc2[0]), 32'd3);
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, $urandom, $urandom);
        check("cont_gcnt1_b3", 32'(oc1[1]), 32'd5);
        check("cont_gcnt2_b3", 32'(oc2[1]), 32'd3);

        // Backpressure on a held 0x55 word, then release into a contested grant.
        cycle(0, 1, 0, 0, 32'h55, 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, $urandom, $urandom);
        check("bp_hold", od[0], 32'h55);
        cycle(0, 1, 1, 0, $urandom, $urandom);

        // Bubble is filled even while downstream stalls.
        cycle(0, 0, 0, 0, 32'h0, 32'h0);
        cycle(0, 1, 0, 1, 32'h77, 32'h0);
        check("bubble_v", 32'(ov[0]), 32'h1);
        check("bubble_data", od[0], 32'h77);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  $urandom, $urandom);

        // Counter saturation on source 1.
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 65538; i++) cycle(0, 1, 0, 0, 32'(i), 32'h0);
        check("sat_gcnt1", 32'(oc1[0]), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
